// File: rtl/fifo_pkt_drainer.sv
// fifo_pkt_drainer: drains sync_fifo words into a packetised valid/ready stream.
// Define STREAM_CKSUM_EN to append an XOR checksum beat after every PKT_LEN data words.
module fifo_pkt_drainer #(
    parameter int DW      = 16,
    parameter int PKT_LEN = 4,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [CW-1:0] pkt_cnt
);
    logic [DW-1:0] mem [2];
    logic          wr_ptr, rd_ptr, inflight, pop_now, last_word;
    logic [1:0]    count;
    logic [2:0]    occ;
    logic [15:0]   idx;

    assign last_word  = idx == 16'(PKT_LEN - 1);
    assign occ        = 3'(count) + 3'(inflight) - 3'(pop_now);
    assign fifo_rd_en = rstn && en && !fifo_empty && occ < 3'd2;

`ifdef STREAM_CKSUM_EN
    typedef enum logic {DATA, CKSUM} state_t;
    state_t        state;
    logic [DW-1:0] acc;

    assign pop_now   = state == DATA && count != 2'd0 && out_ready;
    assign out_valid = (state == DATA && count != 2'd0) || state == CKSUM;
    assign out_data  = state == CKSUM ? acc : mem[rd_ptr];
    assign out_last  = state == CKSUM;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= DATA;
            acc     <= '0;
            idx     <= '0;
            pkt_cnt <= '0;
        end else if (state == CKSUM) begin
            if (out_ready) begin
                state   <= DATA;
                acc     <= '0;
                idx     <= '0;
                pkt_cnt <= pkt_cnt + CW'(1);
            end
        end else if (pop_now) begin
            acc <= acc ^ mem[rd_ptr];
            if (last_word) state <= CKSUM;
            else idx <= idx + 16'd1;
        end
    end
`else
    assign pop_now   = count != 2'd0 && out_ready;
    assign out_valid = count != 2'd0;
    assign out_data  = mem[rd_ptr];
    assign out_last  = count != 2'd0 && last_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx     <= '0;
            pkt_cnt <= '0;
        end else if (pop_now) begin
            idx <= last_word ? 16'd0 : idx + 16'd1;
            if (last_word) pkt_cnt <= pkt_cnt + CW'(1);
        end
    end
`endif

    // FIFO data arrives one cycle after the pop, so capture follows inflight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                mem[wr_ptr] <= fifo_dout;
                wr_ptr      <= !wr_ptr;
            end
            if (pop_now) rd_ptr <= !rd_ptr;
            count <= 2'(occ);
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) !(inflight && count == 2'd2 && !pop_now));
    assert property (@(posedge clk) disable iff (!rstn) !(pop_now && count == 2'd0));
endmodule

// File: tb/tb_fifo_pkt_drainer.sv
// tb_fifo_pkt_drainer: directed bench with a behavioural one-cycle-latency FIFO feeding the drainer.
module tb_fifo_pkt_drainer;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en, out_ready, fifo_rd_en, out_valid, out_last, fifo_empty;
    logic [15:0] fifo_dout, out_data, pkt_cnt;
    logic [15:0] fm [256];
    logic [7:0]  fwr = 8'd0;
    logic [7:0]  frd;
    logic        en1, ready1, rd_en1, valid1, last1;
    logic        empty1 = 1'b0;
    logic [15:0] dout1 = 16'h5A5A;
    logic [15:0] data1;
    logic [3:0]  cnt1;
    int          errors = 0;
    int          checks = 0;
    logic        sb_on, prev_stall, prev_last, seen16;
    logic [15:0] prev_data;
    int          nb;

    typedef struct packed { logic [15:0] d; logic l; } beat_t;
    beat_t exp_q [$];

    typedef struct {
        logic en, rdy, rd_en, valid;
        logic [15:0] data;
        logic last;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    assign fifo_empty = fwr == frd;
    always @(posedge clk or negedge rstn)
        if (!rstn) begin
            frd       <= fwr;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= fm[frd];
            frd       <= frd + 8'd1;
        end

    fifo_pkt_drainer #(.DW(16), .PKT_LEN(4), .CW(16)) u0 (
        .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .pkt_cnt(pkt_cnt)
    );

    fifo_pkt_drainer #(.DW(16), .PKT_LEN(1), .CW(4)) u1 (
        .clk(clk), .rstn(rstn), .en(en1), .fifo_empty(empty1), .fifo_dout(dout1),
        .fifo_rd_en(rd_en1), .out_valid(valid1), .out_ready(ready1),
        .out_data(data1), .out_last(last1), .pkt_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fpush(input logic [15:0] d);
        fm[fwr] = d;
        fwr = fwr + 8'd1;
    endtask

    task automatic expect_beat(input logic [15:0] d, input logic l);
        exp_q.push_back({d, l});
    endtask

    task automatic at_neg();
        beat_t e;
        @(negedge clk);
        if (rstn) begin
            chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'(0));
            if (prev_stall) chk("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_last, prev_data}));
            if (sb_on && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %0h expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({out_last, out_data}), 32'({e.l, e.d}));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        at_neg();
        to_pos();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk({name, "_left"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        en = 1'b0; out_ready = 1'b0; sb_on = 1'b0; prev_stall = 1'b0;
        en1 = 1'b0; ready1 = 1'b0; seen16 = 1'b0; nb = 0;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 16'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd1};

        #1 rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_cnt", 32'(pkt_cnt), 32'(0));
        chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        to_pos();
        rstn = 1'b1;
        tick();

        // basic packet, one word per cycle after start-up
        for (int i = 1; i <= 4; i++) fpush(16'(i));
        for (int i = 0; i < 7; i++) begin
            en = tbl[i].en;
            out_ready = tbl[i].rdy;
            at_neg();
            chk($sformatf("t1_rd_en[%0d]", i), 32'(fifo_rd_en), 32'(tbl[i].rd_en));
            chk($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) chk($sformatf("t1_data[%0d]", i), 32'(out_data), 32'(tbl[i].data));
            chk($sformatf("t1_last[%0d]", i), 32'(out_last), 32'(tbl[i].last));
            chk($sformatf("t1_cnt[%0d]", i), 32'(pkt_cnt), 32'(tbl[i].cnt));
            to_pos();
        end

        // backpressure with ready toggling 1,0,0
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fpush(16'h0010 + 16'(i));
            expect_beat(16'h0010 + 16'(i), i == 3 || i == 7);
        end
        sb_on = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            out_ready = i % 3 == 0;
            tick();
        end
        chk("t2_left", 32'(exp_q.size()), 32'(0));
        chk("t2_cnt", 32'(pkt_cnt), 32'(3));

        // idle then a single late word
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk("t3_idle_valid", 32'(out_valid), 32'(0));
            chk("t3_idle_rd_en", 32'(fifo_rd_en), 32'(0));
            to_pos();
        end
        fpush(16'hBEEF);
        expect_beat(16'hBEEF, 1'b0);
        at_neg();
        chk("t3_pop", 32'(fifo_rd_en), 32'(1));
        chk("t3_valid0", 32'(out_valid), 32'(0));
        to_pos();
        at_neg();
        chk("t3_valid1", 32'(out_valid), 32'(0));
        to_pos();
        at_neg();
        chk("t3_valid2", 32'(out_valid), 32'(1));
        chk("t3_data2", 32'(out_data), 32'(16'hBEEF));
        to_pos();
        for (int i = 1; i <= 3; i++) begin
            fpush(16'hC000 + 16'(i));
            expect_beat(16'hC000 + 16'(i), i == 3);
        end
        drain("t3");
        chk("t3_cnt", 32'(pkt_cnt), 32'(4));

        // en drops mid-packet; buffered words drain, packet completes later
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fpush(16'h0020 + 16'(i));
            expect_beat(16'h0020 + 16'(i), i == 3);
        end
        en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("t4_no_pop", 32'(fifo_rd_en), 32'(0));
            to_pos();
        end
        chk("t4_pending", 32'(exp_q.size()), 32'(1));
        en = 1'b1;
        drain("t4");
        chk("t4_cnt", 32'(pkt_cnt), 32'(5));

        // async reset mid-packet with two words buffered
        en = 1'b0;
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) fpush(16'h0030 + 16'(i));
        out_ready = 1'b0;
        en = 1'b1;
        tick(); tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        #1;
        chk("t5_pre_valid", 32'(out_valid), 32'(1));
        chk("t5_pre_data", 32'(out_data), 32'(16'h0031));
        rstn = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'(0));
        chk("t5_last", 32'(out_last), 32'(0));
        chk("t5_rd_en", 32'(fifo_rd_en), 32'(0));
        chk("t5_cnt", 32'(pkt_cnt), 32'(0));
        prev_stall = 1'b0;
        to_pos();
        rstn = 1'b1;
        sb_on = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fpush(16'h0040 + 16'(i));
            expect_beat(16'h0040 + 16'(i), i == 3);
        end
        drain("t5");
        chk("t5_cnt_after", 32'(pkt_cnt), 32'(1));

        // pkt_cnt wrap with PKT_LEN=1, CW=4
        ready1 = 1'b1;
        en1 = 1'b1;
        for (int i = 0; i < 40 && nb < 17; i++) begin
            at_neg();
            if (valid1 && ready1) begin
                nb++;
                chk("t6_last", 32'(last1), 32'(1));
                chk("t6_data", 32'(data1), 32'(16'h5A5A));
            end
            to_pos();
            if (nb == 16 && !seen16) begin
                seen16 = 1'b1;
                chk("t6_cnt16", 32'(cnt1), 32'(0));
            end
        end
        ready1 = 1'b0;
        chk("t6_beats", 32'(nb), 32'(17));
        chk("t6_cnt17", 32'(cnt1), 32'(1));
        tick(); tick(); tick();
        chk("t6_full_valid", 32'(valid1), 32'(1));
        chk("t6_full_no_pop", 32'(rd_en1), 32'(0));
        en1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
